// File: rtl/clut_writer_if.sv
// Command channel of the CLUT writer: palette commands in, completion pulse out.
interface clut_writer_if #(
   parameter int COLOR_BITS = 4,
   parameter int LINE_SIZE  = 3
);
   // A command moves on a rising edge where cmd_valid && cmd_ready; the
   // master keeps valid and operands steady until then, and done pulses once per command.
   logic                              cmd_valid;
   logic                              cmd_ready;
   logic [1:0]                        cmd_op;
   logic [COLOR_BITS-1:0]             cmd_lo;
   logic [COLOR_BITS-1:0]             cmd_hi;
   logic [COLOR_BITS*LINE_SIZE-1:0]   cmd_color;
   logic                              cmd_dir;
   logic                              done;

   modport master (
      output cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_color, cmd_dir,
      input  cmd_ready, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_color, cmd_dir,
      output cmd_ready, done
   );
endinterface

// File: rtl/clut_writer.sv
// Write-side CLUT controller: expands WRITE/FILL/ROTATE commands into one
// CLUT write per cycle, keeping a shadow palette so rotation never reads the CLUT.
module clut_writer #(
   parameter int COLOR_BITS    = 4,
   parameter int NUM_OF_COLORS = 16,
   parameter int LINE_SIZE     = 3
) (
   input  logic                              clk,
   input  logic                              reset_n,
   clut_writer_if.slave                      cmd,
   output logic                              clut_we,
   output logic [COLOR_BITS-1:0]             clut_addr,
   output logic [COLOR_BITS*LINE_SIZE-1:0]   clut_data,
   output logic [1:0]                        dbg_state_o
);
   localparam int W = COLOR_BITS * LINE_SIZE;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_ROT   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t                state_q;
   logic                  ready_q, done_q, we_q;
   logic [COLOR_BITS-1:0] addr_q;
   logic [W-1:0]          data_q;
   logic [1:0]            op_q;
   logic [COLOR_BITS-1:0] lo_q, hi_q, idx_q;
   logic [W-1:0]          color_q, tmp_q;
   logic                  dir_q;
   logic [W-1:0]          shadow_q [NUM_OF_COLORS];

   logic                  idle;
   logic [1:0]            op_d;
   logic [COLOR_BITS-1:0] lo_d, hi_d, idx_cur_d, idx_next_d;
   logic [W-1:0]          color_d, tmp_cur_d, wr_data_d;
   logic                  dir_d, empty_d, wr_last_d;

   assign idle = (state_q == S_IDLE);

   // In IDLE the first write is built straight from the command inputs so it
   // can appear the cycle after acceptance; afterwards the latched copies are used.
   always_comb begin
      op_d       = idle ? cmd.cmd_op    : op_q;
      lo_d       = idle ? cmd.cmd_lo    : lo_q;
      hi_d       = idle ? cmd.cmd_hi    : hi_q;
      color_d    = idle ? cmd.cmd_color : color_q;
      dir_d      = idle ? cmd.cmd_dir   : dir_q;
      idx_cur_d  = idx_q;
      if (idle) idx_cur_d = (op_d == OP_ROT && dir_d) ? hi_d : lo_d;
      tmp_cur_d  = tmp_q;
      if (idle) tmp_cur_d = dir_d ? shadow_q[hi_d] : shadow_q[lo_d];
      empty_d    = (op_d == 2'b11) || ((op_d != OP_WRITE) && (lo_d > hi_d));
      wr_data_d  = color_d;
      wr_last_d  = 1'b1;
      idx_next_d = idx_cur_d;
      case (op_d)
         OP_FILL: begin
            wr_last_d  = (idx_cur_d == hi_d);
            idx_next_d = idx_cur_d + COLOR_BITS'(1);
         end
         OP_ROT: begin
            if (!dir_d) begin
               wr_last_d  = (idx_cur_d == hi_d);
               wr_data_d  = wr_last_d ? tmp_cur_d : shadow_q[idx_cur_d + COLOR_BITS'(1)];
               idx_next_d = idx_cur_d + COLOR_BITS'(1);
            end else begin
               wr_last_d  = (idx_cur_d == lo_d);
               wr_data_d  = wr_last_d ? tmp_cur_d : shadow_q[idx_cur_d - COLOR_BITS'(1)];
               idx_next_d = idx_cur_d - COLOR_BITS'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         op_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         idx_q   <= '0;
         color_q <= '0;
         tmp_q   <= '0;
         dir_q   <= 1'b0;
         for (int i = 0; i < NUM_OF_COLORS; i++) shadow_q[i] <= '0;
      end else begin
         if (we_q) shadow_q[addr_q] <= data_q;
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               we_q   <= 1'b0;
               if (cmd.cmd_valid && ready_q) begin
                  op_q    <= cmd.cmd_op;
                  lo_q    <= cmd.cmd_lo;
                  hi_q    <= cmd.cmd_hi;
                  color_q <= cmd.cmd_color;
                  dir_q   <= cmd.cmd_dir;
                  tmp_q   <= tmp_cur_d;
                  ready_q <= 1'b0;
                  if (empty_d) begin
                     state_q <= S_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     we_q    <= 1'b1;
                     addr_q  <= idx_cur_d;
                     data_q  <= wr_data_d;
                     done_q  <= wr_last_d;
                     idx_q   <= idx_next_d;
                  end
               end
            end
            S_RUN: begin
               if (done_q) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  done_q  <= 1'b0;
                  we_q    <= 1'b0;
               end else begin
                  we_q   <= 1'b1;
                  addr_q <= idx_cur_d;
                  data_q <= wr_data_d;
                  done_q <= wr_last_d;
                  idx_q  <= idx_next_d;
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd.cmd_ready = ready_q;
   assign cmd.done      = done_q;
   assign clut_we       = we_q;
   assign clut_addr     = addr_q;
   assign clut_data     = data_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_clut_writer.sv
// Bench for clut_writer: directed commands push hand-computed write events into
// a queue; a negedge monitor pops and compares every clut_we/done cycle.
module tb_clut_writer;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_ROT   = 2'b10;
   localparam logic [1:0] OP_RSV   = 2'b11;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clut_we;
   logic [3:0]  clut_addr;
   logic [11:0] clut_data;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // {we, done, addr[3:0], data[11:0]} with the cycle it must appear in
   logic [17:0] exp_q[$];
   int          exp_cyc_q[$];

   clut_writer_if #(.COLOR_BITS(4), .LINE_SIZE(3)) cmd ();

   clut_writer #(.COLOR_BITS(4), .NUM_OF_COLORS(16), .LINE_SIZE(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd         (cmd),
      .clut_we     (clut_we),
      .clut_addr   (clut_addr),
      .clut_data   (clut_data),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic expect_ev(input int c, input logic we, input logic dn,
                            input logic [3:0] a, input logic [11:0] d);
      exp_q.push_back({we, dn, a, d});
      exp_cyc_q.push_back(c);
   endtask

   // Returns at posedge+1 of the accepting edge with acc = that cycle number.
   task automatic send(input logic [1:0] op, input logic [3:0] lo, input logic [3:0] hi,
                       input logic [11:0] color, input logic dir, output int acc);
      int n;
      @(negedge clk);
      cmd.cmd_valid = 1'b1;
      cmd.cmd_op    = op;
      cmd.cmd_lo    = lo;
      cmd.cmd_hi    = hi;
      cmd.cmd_color = color;
      cmd.cmd_dir   = dir;
      n = 0;
      while (!cmd.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd.cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: cmd_ready got 0 expected 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
      acc = cyc;
      cmd.cmd_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (clut_we || cmd.done) begin
         logic [17:0] e;
         int          ec;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d we=%0b done=%0b addr=%0d data=%03h expected no event",
                     cyc, clut_we, cmd.done, clut_addr, clut_data);
         end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (cyc != ec || clut_we !== e[17] || cmd.done !== e[16] ||
                (e[17] && (clut_addr !== e[15:12] || clut_data !== e[11:0]))) begin
               n_fail++;
               $display("FAIL event: got cyc=%0d we=%0b done=%0b addr=%0d data=%03h expected cyc=%0d we=%0b done=%0b addr=%0d data=%03h",
                        cyc, clut_we, cmd.done, clut_addr, clut_data,
                        ec, e[17], e[16], e[15:12], e[11:0]);
            end
         end
      end
   end

   initial begin
      int acc, acc2, busy, n;
      reset_n       = 1'b0;
      cmd.cmd_valid = 1'b0;
      cmd.cmd_op    = OP_WRITE;
      cmd.cmd_lo    = '0;
      cmd.cmd_hi    = '0;
      cmd.cmd_color = '0;
      cmd.cmd_dir   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(cmd.cmd_ready), 1);
      chk("rst_done",  32'(cmd.done), 0);
      chk("rst_we",    32'(clut_we), 0);
      chk("rst_addr",  32'(clut_addr), 0);
      chk("rst_data",  32'(clut_data), 0);
      chk("rst_state", 32'(dbg_state), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // single WRITE and its ready timing
      send(OP_WRITE, 4'd5, 4'd0, 12'hF80, 1'b0, acc);
      expect_ev(acc, 1'b1, 1'b1, 4'd5, 12'hF80);
      chk("write_ready_busy", 32'(cmd.cmd_ready), 0);
      @(posedge clk); #1;
      chk("write_ready_after", 32'(cmd.cmd_ready), 1);

      // full-range FILL, no wrap past 15
      send(OP_FILL, 4'd0, 4'd15, 12'h0A5, 1'b0, acc);
      for (int k = 0; k < 16; k++) expect_ev(acc + k, 1'b1, (k == 15), 4'(k), 12'h0A5);

      // seed 2..5 then rotate down, rotate up, and a one-entry rotate
      for (int k = 2; k <= 5; k++) begin
         send(OP_WRITE, 4'(k), 4'd0, 12'(k * 12'h100), 1'b0, acc);
         expect_ev(acc, 1'b1, 1'b1, 4'(k), 12'(k * 12'h100));
      end
      send(OP_ROT, 4'd2, 4'd5, 12'h000, 1'b0, acc);
      expect_ev(acc,     1'b1, 1'b0, 4'd2, 12'h300);
      expect_ev(acc + 1, 1'b1, 1'b0, 4'd3, 12'h400);
      expect_ev(acc + 2, 1'b1, 1'b0, 4'd4, 12'h500);
      expect_ev(acc + 3, 1'b1, 1'b1, 4'd5, 12'h200);
      send(OP_ROT, 4'd2, 4'd5, 12'h000, 1'b1, acc);
      expect_ev(acc,     1'b1, 1'b0, 4'd5, 12'h500);
      expect_ev(acc + 1, 1'b1, 1'b0, 4'd4, 12'h400);
      expect_ev(acc + 2, 1'b1, 1'b0, 4'd3, 12'h300);
      expect_ev(acc + 3, 1'b1, 1'b1, 4'd2, 12'h200);
      send(OP_ROT, 4'd3, 4'd3, 12'h000, 1'b1, acc);
      expect_ev(acc, 1'b1, 1'b1, 4'd3, 12'h300);

      // empty commands: done only, one cycle later, ready back next cycle
      send(OP_FILL, 4'd9, 4'd3, 12'h777, 1'b0, acc);
      expect_ev(acc, 1'b0, 1'b1, 4'd0, 12'h000);
      chk("empty_fill_ready_busy", 32'(cmd.cmd_ready), 0);
      @(posedge clk); #1;
      chk("empty_fill_ready_after", 32'(cmd.cmd_ready), 1);
      send(OP_RSV, 4'd1, 4'd8, 12'h777, 1'b0, acc);
      expect_ev(acc, 1'b0, 1'b1, 4'd0, 12'h000);
      chk("reserved_ready_busy", 32'(cmd.cmd_ready), 0);
      @(posedge clk); #1;
      chk("reserved_ready_after", 32'(cmd.cmd_ready), 1);

      // reset during the 4th FILL write
      send(OP_FILL, 4'd0, 4'd15, 12'hABC, 1'b0, acc);
      for (int k = 0; k < 4; k++) expect_ev(acc + k, 1'b1, 1'b0, 4'(k), 12'hABC);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_we",    32'(clut_we), 0);
      chk("abort_done",  32'(cmd.done), 0);
      chk("abort_addr",  32'(clut_addr), 0);
      chk("abort_data",  32'(clut_data), 0);
      chk("abort_ready", 32'(cmd.cmd_ready), 1);
      chk("abort_state", 32'(dbg_state), 0);
      @(negedge clk);
      reset_n = 1'b1;
      send(OP_ROT, 4'd0, 4'd15, 12'hFFF, 1'b0, acc);
      for (int k = 0; k < 16; k++) expect_ev(acc + k, 1'b1, (k == 15), 4'(k), 12'h000);

      // valid held with changing operands during a FILL, then back-to-back
      send(OP_FILL, 4'd0, 4'd7, 12'h111, 1'b0, acc);
      for (int k = 0; k < 8; k++) expect_ev(acc + k, 1'b1, (k == 7), 4'(k), 12'h111);
      cmd.cmd_valid = 1'b1;
      busy = 0;
      n    = 0;
      @(negedge clk);
      while (!cmd.cmd_ready && n < 50) begin
         busy++;
         cmd.cmd_op    = 2'($urandom_range(0, 3));
         cmd.cmd_lo    = 4'($urandom_range(0, 15));
         cmd.cmd_hi    = 4'($urandom_range(0, 15));
         cmd.cmd_color = 12'($urandom_range(0, 4095));
         cmd.cmd_dir   = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      cmd.cmd_op    = OP_FILL;
      cmd.cmd_lo    = 4'd1;
      cmd.cmd_hi    = 4'd2;
      cmd.cmd_color = 12'h222;
      cmd.cmd_dir   = 1'b0;
      @(posedge clk); #1;
      acc2 = cyc;
      cmd.cmd_valid = 1'b0;
      expect_ev(acc2,     1'b1, 1'b0, 4'd1, 12'h222);
      expect_ev(acc2 + 1, 1'b1, 1'b1, 4'd2, 12'h222);
      chk("held_valid_busy_cycles", 32'(busy), 8);
      chk("back_to_back_accept_cycle", 32'(acc2), 32'(acc + 9));

      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("events_outstanding", 32'(exp_q.size()), 0);
      chk("final_ready", 32'(cmd.cmd_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/clut_writer.md
Name: clut_writer

Overview:
Command-driven write-side controller for the colour look-up table; it is the only block that drives the CLUT write port (we, addr_write, data_in, clk_write = clk).
Accepts palette commands over a valid/ready handshake: single write, range fill, and range rotate (colour cycling).
Expands each command into a sequence of one-entry-per-cycle CLUT writes.
Keeps a shadow copy of every entry it has written, so rotation never needs the CLUT read port, which stays owned by the display pipeline.

Parameters:
COLOR_BITS, 4, bits per colour channel; also index/address width.
NUM_OF_COLORS, 16, palette entries; must equal 2**COLOR_BITS.
LINE_SIZE, 3, channels per entry (r,g,b); entry width W = COLOR_BITS*LINE_SIZE = 12.

Ports:
clk  in  1  single clock; also drives CLUT clk_write.
reset_n  in  1  synchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready at posedge.
cmd_op  in  2  00 WRITE, 01 FILL, 10 ROTATE, 11 reserved.
cmd_lo  in  COLOR_BITS  first index (WRITE target index).
cmd_hi  in  COLOR_BITS  last index, inclusive (ignored for WRITE).
cmd_color  in  W  colour for WRITE/FILL.
cmd_dir  in  1  ROTATE only: 0 down, 1 up.
done  out  1  one-cycle pulse at command completion.
clut_we  out  1  to CLUT we.
clut_addr  out  COLOR_BITS  to CLUT addr_write.
clut_data  out  W  to CLUT data_in.

Behaviour:
- Operands (op, lo, hi, color, dir) are latched at acceptance. Input changes afterwards have no effect.
- Reset (reset_n low at posedge):
  - state=IDLE, cmd_ready=1, done=0, clut_we=0, clut_addr=0, clut_data=0.
  - Shadow cleared to 0; any in-flight command is aborted with no further writes.
  - The CLUT contents themselves are not touched.
  - Software must WRITE/FILL all entries before ROTATE is meaningful.
- States:
  - IDLE: waits for acceptance; moves to RUN, or to FINISH if the command is empty.
  - RUN: one write per cycle.
  - FINISH: one cycle used only for empty commands.
- All outputs are registered. The first clut_we is asserted the cycle after acceptance.
- Each clut_we cycle also updates shadow[clut_addr] <= clut_data in the same edge.
- WRITE: 1 write, addr=lo, data=color.
- FILL: writes lo, lo+1, ..., hi, each with color; N = hi-lo+1 cycles.
- ROTATE down (dir=0):
  - At acceptance, tmp <= shadow[lo].
  - For i = lo..hi-1, in order: write addr i, data shadow[i+1].
  - Final write: addr hi, data tmp.
  - Result: new[i]=old[i+1], new[hi]=old[lo].
- ROTATE up (dir=1):
  - At acceptance, tmp <= shadow[hi].
  - For i = hi down to lo+1: write addr i, data shadow[i-1].
  - Final write: addr lo, data tmp.
  - Result: new[i]=old[i-1], new[lo]=old[hi].
- ROTATE with lo==hi: single write of the unchanged value.
- Empty/invalid commands produce no CLUT writes:
  - FILL/ROTATE with lo>hi.
  - op=11.
  - Path: IDLE -> FINISH; done pulses the cycle after acceptance; no clut_we.
- done pulses in the same cycle as the final clut_we. The state returns to IDLE on that edge, so cmd_ready is 1 the cycle after done.
- Timing summary:
  - Latency from acceptance to done: N cycles for non-empty commands, 1 cycle for empty ones.
  - Throughput: a back-to-back command can be accepted the cycle after done.
- Full range (lo=0, hi=NUM_OF_COLORS-1) must not wrap: the index counter is COLOR_BITS wide, and termination compares against hi/lo, never by overflow.
- While clut_we=0, clut_addr and clut_data hold their last values. The CLUT ignores them.

Test Plan:
1. Reset then WRITE lo=5 color=0xF80 -> next cycle clut_we=1, addr=5, data=0xF80, done=1; cmd_ready=0 during that cycle, 1 the cycle after.
2. FILL lo=0 hi=15 color=0x0A5 -> 16 consecutive clut_we cycles, addr 0..15, data 0x0A5; done with addr=15; no wrap past 15.
3. After writing entry i = 0x100*i for i=2..5 (0x200, 0x300, 0x400, 0x500), ROTATE lo=2 hi=5 dir=0 -> writes (2,0x300),(3,0x400),(4,0x500),(5,0x200). A following ROTATE dir=1 over the same range restores the original values, written in address order 5,4,3,2.
4. FILL lo=9 hi=3 and op=11 -> zero clut_we; done pulses exactly 1 cycle after acceptance; cmd_ready back next cycle.
5. Start FILL lo=0 hi=15, pull reset_n low at the 4th write -> writes stop next edge, all outputs at reset values. A subsequent ROTATE over 0..15 writes all zeros (shadow cleared).
6. Hold cmd_valid high with changing operands during a FILL -> no acceptance until cmd_ready; the running FILL uses the latched operands; a back-to-back command is accepted the cycle after done.
